// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris piece controller: block and FSM
// enums, board geometry, divider widths and the tetromino spawn-offset table.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 23;
    localparam int X_W     = $clog2(BOARD_W);
    localparam int Y_W     = $clog2(BOARD_H);

    localparam int          DIV_W          = 20;
    localparam int unsigned FAST_FRAME_DIV = 32'd3;
    localparam int unsigned FAST_FALL_DIV  = 32'd2;

    typedef enum logic [2:0] {
        BLK_I = 3'd0,
        BLK_O = 3'd1,
        BLK_T = 3'd2,
        BLK_S = 3'd3,
        BLK_Z = 3'd4,
        BLK_J = 3'd5,
        BLK_L = 3'd6,
        BLK_X = 3'd7
    } block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DROP = 2'd2,
        ST_LAND = 2'd3
    } state_t;

    // 3-bit two's-complement offsets; each table entry packs cells 2..4 as
    // {c4dx,c4dy, c3dx,c3dy, c2dx,c2dy}, so cell 2 sits in bits [5:0].
    localparam logic [2:0] N1 = 3'b111;
    localparam logic [2:0] Z0 = 3'b000;
    localparam logic [2:0] P1 = 3'b001;
    localparam logic [2:0] P2 = 3'b010;

    localparam logic [17:0] SPAWN_OFFSETS [8] = '{
        {P2, Z0, P1, Z0, N1, Z0},   // I
        {P1, N1, Z0, N1, P1, Z0},   // O
        {Z0, P1, P1, Z0, N1, Z0},   // T
        {P1, P1, Z0, P1, N1, Z0},   // S
        {N1, P1, Z0, P1, P1, Z0},   // Z
        {N1, P1, P1, Z0, N1, Z0},   // J
        {P1, P1, P1, Z0, N1, Z0},   // L
        {P1, N1, Z0, N1, P1, Z0}    // code 7 behaves as O
    };

    // Clockwise quarter turns of a packed {dx,dy}; one turn is (dx,dy)->(dy,-dx).
    function automatic logic [5:0] rotate_cw(input logic [5:0] dxy, input logic [1:0] turns);
        logic [2:0] dx;
        logic [2:0] dy;
        dx = dxy[5:3];
        dy = dxy[2:0];
        case (turns)
            2'd0:    rotate_cw = {dx, dy};
            2'd1:    rotate_cw = {dy, 3'd0 - dx};
            2'd2:    rotate_cw = {3'd0 - dx, 3'd0 - dy};
            2'd3:    rotate_cw = {3'd0 - dy, dx};
            default: rotate_cw = {dx, dy};
        endcase
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Enabled down-counter that reloads after zero; tick marks an enabled zero count.
module tick_divider #(
    parameter int unsigned          WIDTH  = 20,
    parameter logic [WIDTH-1:0]     RELOAD = '0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: hold when disabled, reload after zero, otherwise decrement
    always_comb begin
        count_d = count_q;
        if (!en_i) begin
            count_d = count_q;
        end else if (count_q == '0) begin
            count_d = RELOAD;
        end else begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register, reset to the reload value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = en_i & (count_q == '0);

endmodule

// File: rtl/tetris_piece_ctrl.sv
// Frame/gravity tick generation, active-piece load/drop/land FSM and tetromino
// cell expansion. Define TETRIS_FAST_SIM_EN to force divide-by-3 frames and
// divide-by-2 gravity for short simulations.
module tetris_piece_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 833333,
    parameter int unsigned FALL_DIV  = 30
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start_game,
    input  logic           filled_under,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [2:0]     block_type,
    input  logic [1:0]     rotation,
    output logic           frame_tick,
    output logic           fall_tick,
    output logic           load_block,
    output logic           drop_block,
    output logic           update_board_state,
    output logic [X_W-1:0] x1,
    output logic [X_W-1:0] x2,
    output logic [X_W-1:0] x3,
    output logic [X_W-1:0] x4,
    output logic [Y_W-1:0] y1,
    output logic [Y_W-1:0] y2,
    output logic [Y_W-1:0] y3,
    output logic [Y_W-1:0] y4
);

`ifdef TETRIS_FAST_SIM_EN
    localparam logic [DIV_W-1:0] FRAME_RELOAD = DIV_W'(FAST_FRAME_DIV - 32'd1);
    localparam logic [DIV_W-1:0] FALL_RELOAD  = DIV_W'(FAST_FALL_DIV - 32'd1);
`else
    localparam logic [DIV_W-1:0] FRAME_RELOAD = DIV_W'(FRAME_DIV - 32'd1);
    localparam logic [DIV_W-1:0] FALL_RELOAD  = DIV_W'(FALL_DIV - 32'd1);
`endif

    tick_divider #(
        .WIDTH  (DIV_W),
        .RELOAD (FRAME_RELOAD)
    ) u_frame_div (
        .clk_i  (clock),
        .rst_ni (resetn),
        .en_i   (1'b1),
        .tick_o (frame_tick)
    );

    tick_divider #(
        .WIDTH  (DIV_W),
        .RELOAD (FALL_RELOAD)
    ) u_fall_div (
        .clk_i  (clock),
        .rst_ni (resetn),
        .en_i   (frame_tick),
        .tick_o (fall_tick)
    );

    state_t state_q;
    logic   load_q;
    logic   drop_q;
    logic   land_q;

    // Piece FSM; strobes are registered alongside the state they decode
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            drop_q  <= 1'b0;
            land_q  <= 1'b0;
        end else if (fall_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_game) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_DROP;
                    load_q  <= 1'b0;
                    drop_q  <= 1'b1;
                end
                ST_DROP: begin
                    if (filled_under) begin
                        state_q <= ST_LAND;
                        drop_q  <= 1'b0;
                        land_q  <= 1'b1;
                    end
                end
                ST_LAND: begin
                    state_q <= ST_LOAD;
                    land_q  <= 1'b0;
                    load_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    load_q  <= 1'b0;
                    drop_q  <= 1'b0;
                    land_q  <= 1'b0;
                end
            endcase
        end
    end

    // The drop strobe must fall in the same cycle the cell below becomes occupied
    assign load_block         = load_q;
    assign drop_block         = drop_q & ~filled_under;
    assign update_board_state = land_q;

    logic [17:0]    offs_s;
    logic [1:0]     turns_s;
    logic [5:0]     d_s;
    logic [X_W-1:0] cx_s [4];
    logic [Y_W-1:0] cy_s [4];

    // Expand centre + rotated spawn offsets into four cells, wrapping modulo width
    always_comb begin
        offs_s = SPAWN_OFFSETS[block_type];
        if (block_t'(block_type) == BLK_O || block_t'(block_type) == BLK_X) begin
            turns_s = 2'd0;
        end else begin
            turns_s = rotation;
        end
        d_s     = 6'd0;
        cx_s[0] = x;
        cy_s[0] = y;
        for (int k = 1; k < 4; k++) begin
            d_s     = rotate_cw(offs_s[6*(k-1) +: 6], turns_s);
            cx_s[k] = x + {d_s[5], d_s[5:3]};
            cy_s[k] = y + {{2{d_s[2]}}, d_s[2:0]};
        end
    end

    assign x1 = cx_s[0];
    assign y1 = cy_s[0];
    assign x2 = cx_s[1];
    assign y2 = cy_s[1];
    assign x3 = cx_s[2];
    assign y3 = cy_s[2];
    assign x4 = cx_s[3];
    assign y4 = cy_s[3];

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
// Self-checking bench for tetris_piece_ctrl: directed expansion vectors plus
// randomized play checked every cycle against a behavioural game model.
module tb_tetris_piece_ctrl;

`ifdef TETRIS_FAST_SIM_EN
    localparam int FD = 3;
    localparam int FL = 2;
`else
    localparam int FD = 4;
    localparam int FL = 3;
`endif
    localparam int GP = FD * FL;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start_game;
    logic       filled_under;
    logic [3:0] x;
    logic [4:0] y;
    logic [2:0] block_type;
    logic [1:0] rotation;
    logic       frame_tick;
    logic       fall_tick;
    logic       load_block;
    logic       drop_block;
    logic       update_board_state;
    logic [3:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int mphase  = 0;   // 0 idle, 1 load, 2 drop, 3 land

    int offs_dx [8][3] = '{'{-1, 1, 2}, '{1, 0, 1}, '{-1, 1, 0}, '{-1, 0, 1},
                           '{1, 0, -1}, '{-1, 1, -1}, '{-1, 1, 1}, '{1, 0, 1}};
    int offs_dy [8][3] = '{'{0, 0, 0}, '{0, -1, -1}, '{0, 0, 1}, '{0, 1, 1},
                           '{0, 1, 1}, '{0, 0, 1}, '{0, 0, 1}, '{0, -1, -1}};

    tetris_piece_ctrl #(
        .FRAME_DIV (4),
        .FALL_DIV  (3)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .start_game         (start_game),
        .filled_under       (filled_under),
        .x                  (x),
        .y                  (y),
        .block_type         (block_type),
        .rotation           (rotation),
        .frame_tick         (frame_tick),
        .fall_tick          (fall_tick),
        .load_block         (load_block),
        .drop_block         (drop_block),
        .update_board_state (update_board_state),
        .x1                 (x1),
        .x2                 (x2),
        .x3                 (x3),
        .x4                 (x4),
        .y1                 (y1),
        .y2                 (y2),
        .y3                 (y3),
        .y4                 (y4)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit is_fall(input int c);
        return (c % GP) == GP - 1;
    endfunction

    function automatic void model_cell(input int bt, input int rot, input int cx, input int cy,
                                       input int k, output logic [3:0] ex, output logic [4:0] ey);
        int dx;
        int dy;
        int t;
        int b;
        int r;
        b = (bt == 7) ? 1 : bt;
        if (k == 0) begin
            dx = 0;
            dy = 0;
        end else begin
            dx = offs_dx[b][k-1];
            dy = offs_dy[b][k-1];
        end
        r = (b == 1) ? 0 : rot;
        for (int i = 0; i < r; i++) begin
            t  = dx;
            dx = dy;
            dy = -t;
        end
        ex = 4'((cx + dx) & 15);
        ey = 5'((cy + dy) & 31);
    endfunction

    task automatic check_all();
        logic [3:0] ex;
        logic [4:0] ey;
        logic [8:0] obs [4];
        bit         run;
        obs[0] = {x1, y1};
        obs[1] = {x2, y2};
        obs[2] = {x3, y3};
        obs[3] = {x4, y4};
        for (int k = 0; k < 4; k++) begin
            model_cell(int'(block_type), int'(rotation), int'(x), int'(y), k, ex, ey);
            check($sformatf("cell%0d", k + 1), 64'(obs[k]), 64'({ex, ey}));
        end
        run = (resetn === 1'b1);
        check("frame_tick", 64'(frame_tick), 64'(run && (cyc % FD) == FD - 1));
        check("fall_tick", 64'(fall_tick), 64'(run && is_fall(cyc)));
        check("load_block", 64'(load_block), 64'(mphase == 1));
        check("drop_block", 64'(drop_block), 64'(mphase == 2 && filled_under == 1'b0));
        check("update_board_state", 64'(update_board_state), 64'(mphase == 3));
    endtask

    task automatic step(input logic sg, input logic fu, input bit rnd);
        start_game   = sg;
        filled_under = fu;
        if (rnd) begin
            x          = 4'($urandom);
            y          = 5'($urandom);
            block_type = 3'($urandom);
            rotation   = 2'($urandom);
        end
        #1;
        check_all();
        if (resetn === 1'b1 && is_fall(cyc)) begin
            case (mphase)
                0:       if (sg) mphase = 1;
                1:       mphase = 2;
                2:       if (fu) mphase = 3;
                default: mphase = 1;
            endcase
        end
        @(posedge clock);
        if (resetn === 1'b1) cyc++;
        @(negedge clock);
    endtask

    task automatic vec(input string tag, input logic [2:0] bt, input logic [3:0] cx,
                       input logic [4:0] cy, input logic [1:0] rot, input logic [35:0] exp);
        block_type = bt;
        x          = cx;
        y          = cy;
        rotation   = rot;
        #1;
        check(tag, 64'({x1, y1, x2, y2, x3, y3, x4, y4}), 64'(exp));
    endtask

    task automatic run_until_land(input int need_drops);
        int   drops;
        int   n;
        logic sg_v;
        logic fu_v;
        drops = 0;
        n     = 0;
        while (mphase != 3 && n < 30 * GP) begin
            if (is_fall(cyc)) begin
                sg_v = 1'b1;
                fu_v = (mphase == 2 && drops >= need_drops);
                if (mphase == 2 && !fu_v) drops++;
            end else begin
                sg_v = 1'($urandom);
                fu_v = 1'($urandom);
            end
            step(sg_v, fu_v, 1'b1);
            n++;
        end
        check("land_reached", 64'(update_board_state), 64'(1));
    endtask

    initial begin
        resetn       = 1'b0;
        start_game   = 1'b0;
        filled_under = 1'b0;
        x            = 4'd0;
        y            = 5'd0;
        block_type   = 3'd0;
        rotation     = 2'd0;
        @(negedge clock);

        vec("T_rot0", 3'd2, 4'd4, 5'd10, 2'd0, {4'd4, 5'd10, 4'd3, 5'd10, 4'd5, 5'd10, 4'd4, 5'd11});
        vec("T_rot1", 3'd2, 4'd4, 5'd10, 2'd1, {4'd4, 5'd10, 4'd4, 5'd11, 4'd4, 5'd9, 4'd5, 5'd10});
        vec("I_rot2", 3'd0, 4'd4, 5'd10, 2'd2, {4'd4, 5'd10, 4'd5, 5'd10, 4'd3, 5'd10, 4'd2, 5'd10});
        vec("O_rot3", 3'd1, 4'd4, 5'd10, 2'd3, {4'd4, 5'd10, 4'd5, 5'd10, 4'd4, 5'd9, 4'd5, 5'd9});
        vec("type7_rot1", 3'd7, 4'd4, 5'd10, 2'd1, {4'd4, 5'd10, 4'd5, 5'd10, 4'd4, 5'd9, 4'd5, 5'd9});
        vec("I_wrap", 3'd0, 4'd15, 5'd0, 2'd1, {4'd15, 5'd0, 4'd15, 5'd1, 4'd15, 5'd31, 4'd15, 5'd30});

        repeat (2) step(1'b1, 1'b1, 1'b1);

        resetn = 1'b1;
        cyc    = 0;
        repeat (2 * GP) step(1'b0, 1'($urandom), 1'b1);

        run_until_land(3);
        repeat (GP) step(1'($urandom), 1'($urandom), 1'b1);
        run_until_land(0);
        repeat (FD) step(1'($urandom), 1'($urandom), 1'b1);

        resetn = 1'b0;
        mphase = 0;
        cyc    = 0;
        repeat (2) step(1'b1, 1'b0, 1'b1);

        resetn = 1'b1;
        repeat (6 * GP) step(1'($urandom), 1'($urandom_range(0, 2) == 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
